spi_master_gen: RTL and testbench
=================================

# spi_master_gen

Parametrised SPI master: the next generation of the single-slave `spi_master` used with the `lis3dh_stub` benches. It adds a generic data width, multiple chip selects, runtime CPOL/CPHA selection and a captured MISO word. It sits between a register/controller front end using the `request`/`ready` handshake and one or more SPI slave devices.

## Interface
- `DATA_W`, 32: maximum transfer length in bits; must be at least 8.
- `NCS`, 2: number of chip-select lines; must be at least 1.
- `DIV_W`, 16: width of the clock-divider coefficient.
- `DIV_COEF`, 1: fixed divider coefficient. 0 selects the runtime-loadable divider.
- Local widths: `NB_W = $clog2(DATA_W)` and `CS_W = max(1, $clog2(NCS))`.

Ports:
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `request`  in  1  start strobe, sampled only in IDLE.
- `ready`  out  1  high when IDLE and able to accept a request.
- `nbits`  in  NB_W  transfer length minus 1.
- `mosi_data`  in  DATA_W  transmit word, right-aligned. Also carries the divider load value.
- `cs_sel`  in  CS_W  chip-select index.
- `mode`  in  2  {CPOL, CPHA}.
- `miso_data`  out  DATA_W  received word, right-aligned, upper bits zero.
- `miso_valid`  out  1  one-cycle pulse when `miso_data` updates.
- `spi_cen`  out  NCS  active-low chip selects.
- `spi_scl`  out  1  serial clock.
- `spi_sdi`  out  1  MOSI.
- `spi_sdo`  in  1  MISO.
- Present only with `SPI3WIRE_EN`: `spi3w` in 1, `spi_sdi_in` in 1, `spi_sdi_oe` out 1.

## Operation
- H = half-period of SCL, in `clk_in` cycles.
  - `DIV_COEF` ≠ 0: H = `DIV_COEF` + 1.
  - `DIV_COEF` = 0: H = `div_reg` + 1. `div_reg` loads `mosi_data[DIV_W-1:0]` on any edge where `nrst`=0 and `request`=1. Otherwise `div_reg` holds its value. It is not cleared by reset.
- State machine: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - `ready`=1.
  - On `request`=1 with `cs_sel` < NCS, latch `mosi_data`, `nbits`, `cs_sel` and `mode`, then go to SETUP.
  - A request with `cs_sel` ≥ NCS is ignored; `ready` stays high.
- Outside IDLE, `request` is ignored.
- SETUP: assert `spi_cen[cs_sel]`=0. SCL stays at CPOL. The first bit is on `spi_sdi`. Lasts H cycles.
- SHIFT: 2·(nbits+1) SCL edges, spaced H cycles apart.
  - Bit order is MSB first, starting at bit `nbits` of the latched word.
  - CPHA=0: sample `spi_sdo` on the leading edge; drive the next bit on the trailing edge.
  - CPHA=1: drive the next bit on the leading edge; sample on the trailing edge.
- HOLD: H cycles after the last edge. Then `spi_cen` goes all-ones, `miso_data` updates and `miso_valid` pulses, all in the same cycle.
- GAP: H cycles with `spi_cen` all-ones, then IDLE.
- Received bits shift in at the LSB. `miso_data[DATA_W-1:nbits+1]` = 0.
- Reset values: state IDLE, `ready`=1, `spi_cen` all-ones, `spi_scl`=0, `spi_sdi`=0, `miso_data`=0, `miso_valid`=0, latched mode=0, `spi_sdi_oe`=1.
- Reset mid-transfer: on the next edge, all outputs take their reset values. No `miso_valid` pulse is generated.

## Timing
- Reference point: request accepted at edge T.
  - `ready` falls and `spi_cen` asserts at T+1.
  - SCL edge k (k = 1..2·nb, nb = nbits+1) occurs at T+1+k·H.
  - `spi_cen` deasserts and `miso_valid` pulses at T+1+(2nb+1)·H.
  - `ready` rises at T+1+(2nb+2)·H.
- A new request is accepted on the same edge on which `ready` is first seen high.
- H=1 (coefficient 0) is legal: SCL toggles every `clk_in` cycle.

## Configuration
- `SPI3WIRE_EN` defined: adds `spi3w`, `spi_sdi_in` and `spi_sdi_oe`.
  - With `spi3w` latched at 1 and bit 7 of the first transmitted byte equal to 1 (read): `spi_sdi_oe` drops to 0 on the edge after the 8th bit is sampled.
  - The remaining bits are sampled from `spi_sdi_in` instead of `spi_sdo`.
  - `spi_sdi_oe` returns to 1 when `spi_cen` deasserts.
  - With `spi3w`=0, behaviour is identical to 4-wire.
- `SPI3WIRE_EN` undefined: the ports are absent and the block is 4-wire only.

## Test plan
- Basic 4-wire read: `DIV_COEF`=1, mode 0, cs 0, nbits=15, `mosi_data`=0x8F00 to `lis3dh_stub` → `spi_cen`=2'b10 for the transfer, SCL period 4 cycles, 16 rising edges, `spi_sdi` carries 1000_1111_0000_0000, `miso_data`=0x00000033.
- Runtime divider: `DIV_COEF`=0; `request`=1 with `mosi_data`=5 during reset → SCL period 12 cycles; `ready` rises 1+34·6 = 205 cycles after an nbits=15 request.
- Mode 3 loopback: `spi_sdo` tied to `spi_sdi`, mode 3, cs 1, nbits=7, `mosi_data`=0xA5 → SCL idles high, only `spi_cen[1]` asserts, `miso_data`=0x000000A5, single `miso_valid` pulse.
- Ignored requests: `request` pulsed mid-transfer, then `request` with `cs_sel`=NCS while idle → neither changes `spi_cen`; `ready` behaviour unaffected.
- Reset mid-transfer: `nrst`=0 after the 5th SCL edge → next cycle `spi_cen` all-ones, `spi_scl`=0, `ready`=1, no `miso_valid`.
- 3-wire (`SPI3WIRE_EN`): write 0x2301 with `spi3w`=0, then read 0x8F00 with `spi3w`=1 → `spi_sdi_oe`=0 after bit 8, `miso_data[7:0]`=0x33.

Source files
------------

// File: rtl/spi_master_gen.sv
// Parametrised SPI master with NCS chip selects, runtime CPOL/CPHA and a captured MISO word.
// Define SPI3WIRE_EN to add the 3-wire half-duplex read turnaround (spi3w/spi_sdi_in/spi_sdi_oe).

module spi_master_gen #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NCS      = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DIV_COEF = 1,
  localparam int unsigned NB_W    = $clog2(DATA_W),
  localparam int unsigned CS_W    = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              clk_in,
  input  logic              nrst,
  input  logic              request,
  output logic              ready,
  input  logic [NB_W-1:0]   nbits,
  input  logic [DATA_W-1:0] mosi_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] miso_data,
  output logic              miso_valid,
  output logic [NCS-1:0]    spi_cen,
  output logic              spi_scl,
  output logic              spi_sdi,
`ifdef SPI3WIRE_EN
  input  logic              spi3w,
  input  logic              spi_sdi_in,
  output logic              spi_sdi_oe,
`endif
  input  logic              spi_sdo
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0]  div_q, div_val, cnt_q;
  logic              tick, cs_ok, lead, last_edge;
  logic              accept, edge_en, sample_en, hold_done;
  logic              sample_bit;
  logic [DATA_W-1:0] tx_q, rx_q, miso_q;
  logic [NB_W-1:0]   idx_q;
  logic              cpol_q, cpha_q, scl_q, sdi_q, valid_q;
  logic [NCS-1:0]    cen_q;

  // Runtime divider is loaded only while held in reset with request high; reset never clears it.
  always_ff @(posedge clk_in) begin
    if (!nrst && request) begin
      div_q <= mosi_data[DIV_W-1:0];
    end
  end

  assign div_val = (DIV_COEF != 0) ? DIV_W'(DIV_COEF) : div_q;
  assign tick    = (cnt_q == div_val);
  assign cs_ok   = (32'(cs_sel) < NCS);
  // An edge is leading when SCL is still at its idle level.
  assign lead      = (scl_q == cpol_q);
  assign last_edge = !lead && (idx_q == '0);

  always_ff @(posedge clk_in) begin
    if (!nrst || state_q == StIdle || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (request && cs_ok)  state_d = StSetup;
      StSetup: if (tick)              state_d = StShift;
      StShift: if (tick && last_edge) state_d = StHold;
      StHold:  if (tick)              state_d = StGap;
      StGap:   if (tick)              state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  always_comb begin
    ready     = (state_q == StIdle);
    accept    = (state_q == StIdle) && request && cs_ok;
    edge_en   = tick && ((state_q == StSetup) || (state_q == StShift));
    sample_en = edge_en && (lead != cpha_q);
    hold_done = tick && (state_q == StHold);
  end

  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      tx_q    <= '0;
      rx_q    <= '0;
      miso_q  <= '0;
      idx_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      scl_q   <= 1'b0;
      sdi_q   <= 1'b0;
      valid_q <= 1'b0;
      cen_q   <= '1;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        tx_q   <= mosi_data;
        rx_q   <= '0;
        idx_q  <= nbits;
        cpol_q <= mode[1];
        cpha_q <= mode[0];
        scl_q  <= mode[1];
        sdi_q  <= mosi_data[nbits];
        cen_q  <= ~(NCS'(1) << cs_sel);
      end
      if (edge_en) begin
        scl_q <= ~scl_q;
        if (lead) begin
          if (cpha_q) sdi_q <= tx_q[idx_q];
        end else if (idx_q != '0) begin
          idx_q <= idx_q - 1'b1;
          if (!cpha_q) sdi_q <= tx_q[idx_q - 1'b1];
        end
      end
      if (sample_en) begin
        rx_q <= {rx_q[DATA_W-2:0], sample_bit};
      end
      if (hold_done) begin
        cen_q   <= '1;
        miso_q  <= rx_q;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef SPI3WIRE_EN
  logic       rd_q, oe_q;
  logic [3:0] samp_q;

  // Read is flagged by bit 7 of the command byte, i.e. the first bit sent.
  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      rd_q   <= 1'b0;
      oe_q   <= 1'b1;
      samp_q <= '0;
    end else begin
      if (accept) begin
        rd_q   <= spi3w & mosi_data[nbits];
        samp_q <= '0;
      end
      if (sample_en && samp_q != 4'd8) samp_q <= samp_q + 4'd1;
      if (edge_en && rd_q && samp_q == 4'd8) oe_q <= 1'b0;
      if (hold_done) oe_q <= 1'b1;
    end
  end

  assign sample_bit = oe_q ? spi_sdo : spi_sdi_in;
  assign spi_sdi_oe = oe_q;
`else
  assign sample_bit = spi_sdo;
`endif

  assign miso_data  = miso_q;
  assign miso_valid = valid_q;
  assign spi_cen    = cen_q;
  assign spi_scl    = scl_q;
  assign spi_sdi    = sdi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: fixed-divider instance (NCS=3) and runtime-divider instance.

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) passed++; \
    else $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
  end

module tb_spi_master_gen;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        request = 1'b0;
  logic        ready;
  logic [4:0]  nbits = '0;
  logic [31:0] mosi_data = '0;
  logic [1:0]  cs_sel = '0;
  logic [1:0]  mode = '0;
  logic [31:0] miso_data;
  logic        miso_valid;
  logic [2:0]  spi_cen;
  logic        spi_scl, spi_sdi, spi_sdo;
  logic        loop_en = 1'b0;

  logic        r_request = 1'b0;
  logic        r_ready;
  logic [4:0]  r_nbits = '0;
  logic [31:0] r_mosi = '0;
  logic        r_cs = 1'b0;
  logic [1:0]  r_mode = '0;
  logic [31:0] r_miso;
  logic        r_valid;
  logic [1:0]  r_cen;
  logic        r_scl, r_sdi;
  logic        r_sdo = 1'b0;

  int checks = 0;
  int passed = 0;

  int          n_edges, t_e1, t_e3, t_valid, n_valid, t_ready, cen_bad;
  logic [31:0] cap;

  // Mode-0 slave: presents slv_word MSB first, advancing after each SCL rising edge.
  logic [15:0] slv_word = 16'h0033;
  logic [4:0]  slv_cnt = 5'd0;
  logic        slv_bit;

  always #5 clk = ~clk;

  always @(posedge spi_scl or posedge spi_cen[0]) begin
    if (spi_cen[0]) slv_cnt <= 5'd0;
    else            slv_cnt <= slv_cnt + 5'd1;
  end

  always_comb begin
    slv_bit = 1'b0;
    if (slv_cnt < 5'd16) slv_bit = slv_word[4'd15 - slv_cnt[3:0]];
  end

  assign spi_sdo = loop_en ? spi_sdi : slv_bit;

  spi_master_gen #(
    .DATA_W   (32),
    .NCS      (3),
    .DIV_W    (16),
    .DIV_COEF (1)
  ) u_dut (
    .clk_in     (clk),
    .nrst       (nrst),
    .request    (request),
    .ready      (ready),
    .nbits      (nbits),
    .mosi_data  (mosi_data),
    .cs_sel     (cs_sel),
    .mode       (mode),
    .miso_data  (miso_data),
    .miso_valid (miso_valid),
    .spi_cen    (spi_cen),
    .spi_scl    (spi_scl),
    .spi_sdi    (spi_sdi),
    .spi_sdo    (spi_sdo)
  );

  spi_master_gen #(
    .DATA_W   (32),
    .NCS      (2),
    .DIV_W    (16),
    .DIV_COEF (0)
  ) u_dut_rt (
    .clk_in     (clk),
    .nrst       (nrst),
    .request    (r_request),
    .ready      (r_ready),
    .nbits      (r_nbits),
    .mosi_data  (r_mosi),
    .cs_sel     (r_cs),
    .mode       (r_mode),
    .miso_data  (r_miso),
    .miso_valid (r_valid),
    .spi_cen    (r_cen),
    .spi_scl    (r_scl),
    .spi_sdi    (r_sdi),
    .spi_sdo    (r_sdo)
  );

  // Follows one transfer from the negedge after acceptance until ready is seen high again.
  task automatic watch(input logic [1:0] md, input int pulse_at, input logic [2:0] cen_exp);
    logic prev, lead;
    prev = spi_scl;
    n_edges = 0; t_e1 = -1; t_e3 = -1; t_valid = -1; n_valid = 0; t_ready = -1; cen_bad = 0;
    cap = '0;
    for (int i = 0; i < 400; i++) begin
      request = (i == pulse_at);
      if (i == pulse_at) begin
        cs_sel    = 2'd0;
        mosi_data = 32'hFF;
      end
      if (spi_scl !== prev) begin
        n_edges++;
        if (n_edges == 1) t_e1 = i;
        if (n_edges == 3) t_e3 = i;
        lead = (prev == md[1]);
        if (lead != md[0]) cap = {cap[30:0], spi_sdi};
      end
      prev = spi_scl;
      if (miso_valid) begin
        n_valid++;
        t_valid = i;
      end else if (t_valid < 0 && spi_cen !== cen_exp) begin
        cen_bad++;
      end
      if (ready) begin
        t_ready = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic prev;
    int   n, nv, rise1, rise2, tr;

    // Reset, loading the runtime divider with 5 (H = 6).
    r_request = 1'b1;
    r_mosi    = 32'd5;
    repeat (3) @(negedge clk);
    `CHK("rst_ready", ready, 1'b1)
    `CHK("rst_cen", spi_cen, 3'b111)
    `CHK("rst_scl", spi_scl, 1'b0)
    `CHK("rst_sdi", spi_sdi, 1'b0)
    `CHK("rst_miso", miso_data, 32'h0)
    `CHK("rst_valid", miso_valid, 1'b0)
    nrst      = 1'b1;
    r_request = 1'b0;
    r_mosi    = '0;
    @(negedge clk);

    // Basic 4-wire read, mode 0, cs 0, H = 2.
    nbits = 5'd15; mosi_data = 32'h8F00; cs_sel = 2'd0; mode = 2'd0; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    `CHK("b_ready", ready, 1'b0)
    `CHK("b_cen", spi_cen, 3'b110)
    `CHK("b_scl", spi_scl, 1'b0)
    `CHK("b_sdi0", spi_sdi, 1'b1)
    watch(2'b00, -1, 3'b110);
    `CHK("b_edge1", t_e1, 2)
    `CHK("b_period", t_e3 - t_e1, 4)
    `CHK("b_edges", n_edges, 32)
    `CHK("b_mosi", cap, 32'h8F00)
    `CHK("b_nvalid", n_valid, 1)
    `CHK("b_tvalid", t_valid, 66)
    `CHK("b_tready", t_ready, 68)
    `CHK("b_cen_hold", cen_bad, 0)
    `CHK("b_miso", miso_data, 32'h33)

    // Mode 3 loopback on cs 1, requested on the edge ready is first seen; mid-transfer request.
    loop_en = 1'b1;
    nbits = 5'd7; mosi_data = 32'hA5; cs_sel = 2'd1; mode = 2'd3; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    `CHK("m3_scl_idle", spi_scl, 1'b1)
    `CHK("m3_cen", spi_cen, 3'b101)
    watch(2'b11, 10, 3'b101);
    `CHK("m3_edge1", t_e1, 2)
    `CHK("m3_period", t_e3 - t_e1, 4)
    `CHK("m3_edges", n_edges, 16)
    `CHK("m3_mosi", cap, 32'hA5)
    `CHK("m3_nvalid", n_valid, 1)
    `CHK("m3_tvalid", t_valid, 34)
    `CHK("m3_tready", t_ready, 36)
    `CHK("m3_cen_hold", cen_bad, 0)
    `CHK("m3_miso", miso_data, 32'hA5)
    `CHK("m3_scl_end", spi_scl, 1'b1)

    // Request to a nonexistent chip select is ignored.
    cs_sel = 2'd3; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    `CHK("bad_cs_ready", ready, 1'b1)
    `CHK("bad_cs_cen", spi_cen, 3'b111)
    repeat (3) @(negedge clk);
    `CHK("bad_cs_ready2", ready, 1'b1)
    `CHK("bad_cs_valid", miso_valid, 1'b0)

    // Reset after the 5th SCL edge of a transfer.
    loop_en = 1'b0;
    nbits = 5'd15; mosi_data = 32'h8F00; cs_sel = 2'd0; mode = 2'd0; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    prev = spi_scl;
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (spi_scl !== prev) n++;
      prev = spi_scl;
    end
    `CHK("rm_edges", n, 5)
    nrst = 1'b0;
    @(negedge clk);
    `CHK("rm_cen", spi_cen, 3'b111)
    `CHK("rm_scl", spi_scl, 1'b0)
    `CHK("rm_sdi", spi_sdi, 1'b0)
    `CHK("rm_ready", ready, 1'b1)
    `CHK("rm_valid", miso_valid, 1'b0)
    nrst = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (miso_valid) nv++;
    end
    `CHK("rm_no_valid", nv, 0)
    `CHK("rm_miso", miso_data, 32'h0)

    // Runtime divider (loaded as 5 during the first reset, kept through the second).
    r_nbits = 5'd15; r_mosi = 32'h1234; r_cs = 1'b0; r_mode = 2'd0; r_request = 1'b1;
    @(negedge clk);
    r_request = 1'b0;
    `CHK("rt_ready", r_ready, 1'b0)
    `CHK("rt_cen", r_cen, 2'b10)
    prev = r_scl;
    rise1 = -1; rise2 = -1; tr = -1;
    for (int i = 0; i < 400; i++) begin
      if (r_scl && !prev) begin
        if (rise1 < 0)      rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev = r_scl;
      if (r_ready) begin
        tr = i;
        break;
      end
      @(negedge clk);
    end
    `CHK("rt_rise1", rise1, 6)
    `CHK("rt_period", rise2 - rise1, 12)
    `CHK("rt_tready", tr, 204)
    `CHK("rt_miso", r_miso, 32'h0)

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
